// File: rtl/dk_sprite_fetch.sv
// Donkey Kong sprite pixel source: box test, mirrored/animated ROM addressing, and the aligned RGB565 output.
// Two cycles from an accepted pixel to img/img_valid at one pixel per cycle; free-running with no stall or backpressure.
module dk_sprite_fetch #(
  parameter int          SPR_W     = 80,
  parameter int          SPR_H     = 100,
  parameter int          FRAMES    = 4,
  parameter int          FRAME_DIV = 6,
  parameter int          ADDR_W    = 15,
  parameter logic [15:0] KEY       = 16'h0E3B
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              frame_start,
  input  logic              pix_valid,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic [9:0]        DK_X,
  input  logic [9:0]        DK_Y,
  input  logic              moving,
  input  logic              facing_left,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic [15:0]       img,
  output logic              img_valid,
  output logic [9:0]        out_DrawX,
  output logic [9:0]        out_DrawY
);

  localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int FRM_W = (FRAMES > 1) ? $clog2(FRAMES) : 1;
  localparam logic [ADDR_W-1:0] FRAME_SZ = ADDR_W'(SPR_W * SPR_H);

  logic [9:0]        sx_q, sx_d, sy_q, sy_d;
  logic              face_q, face_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [FRM_W-1:0]  frame_q, frame_d;

  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              vld1_q, vld1_d, box1_q, box1_d;
  logic [9:0]        x1_q, x1_d, y1_q, y1_d;
  logic              vld2_q, vld2_d, box2_q, box2_d;
  logic [9:0]        x2_q, x2_d, y2_q, y2_d;
  logic [15:0]       img_q, img_d;
  logic              img_vld_q, img_vld_d;
  logic [9:0]        ox_q, ox_d, oy_q, oy_d;

  logic [10:0]       x11, y11, sx11, sy11;
  logic              in_box;
  logic [9:0]        lx_raw, lx, ly;
  logic [ADDR_W-1:0] addr_calc;

  always_comb begin
    sx_d    = sx_q;
    sy_d    = sy_q;
    face_d  = face_q;
    div_d   = div_q;
    frame_d = frame_q;
    if (frame_start) begin
      sx_d   = DK_X;
      sy_d   = DK_Y;
      face_d = facing_left;
      if (moving) begin
        if (int'(div_q) == FRAME_DIV - 1) begin
          div_d   = '0;
          frame_d = (int'(frame_q) == FRAMES - 1) ? '0 : frame_q + FRM_W'(1);
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end else begin
        div_d   = '0;
        frame_d = '0;
      end
    end
  end

  // Stage 0 uses the next-state shadows so a pixel coinciding with frame_start sees the new frame.
  always_comb begin
    x11    = {1'b0, DrawX};
    y11    = {1'b0, DrawY};
    sx11   = {1'b0, sx_d};
    sy11   = {1'b0, sy_d};
    in_box = (x11 >= sx11) && (x11 < sx11 + 11'(SPR_W)) &&
             (y11 >= sy11) && (y11 < sy11 + 11'(SPR_H));
    lx_raw = DrawX - sx_d;
    lx     = face_d ? (10'(SPR_W - 1) - lx_raw) : lx_raw;
    ly     = DrawY - sy_d;
    addr_calc = ADDR_W'(frame_d) * FRAME_SZ + ADDR_W'(ly) * ADDR_W'(SPR_W) + ADDR_W'(lx);

    rom_addr_d = rom_addr_q;
    if (pix_valid) rom_addr_d = in_box ? addr_calc : '0;
    vld1_d = pix_valid;
    box1_d = pix_valid && in_box;
    x1_d   = DrawX;
    y1_d   = DrawY;

    vld2_d = vld1_q;
    box2_d = box1_q;
    x2_d   = x1_q;
    y2_d   = y1_q;

    img_d     = box2_q ? rom_data : KEY;
    img_vld_d = vld2_q;
    ox_d      = x2_q;
    oy_d      = y2_q;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sx_q       <= '0;
      sy_q       <= '0;
      face_q     <= 1'b0;
      div_q      <= '0;
      frame_q    <= '0;
      rom_addr_q <= '0;
      vld1_q     <= 1'b0;
      box1_q     <= 1'b0;
      x1_q       <= '0;
      y1_q       <= '0;
      vld2_q     <= 1'b0;
      box2_q     <= 1'b0;
      x2_q       <= '0;
      y2_q       <= '0;
      img_q      <= KEY;
      img_vld_q  <= 1'b0;
      ox_q       <= '0;
      oy_q       <= '0;
    end else begin
      sx_q       <= sx_d;
      sy_q       <= sy_d;
      face_q     <= face_d;
      div_q      <= div_d;
      frame_q    <= frame_d;
      rom_addr_q <= rom_addr_d;
      vld1_q     <= vld1_d;
      box1_q     <= box1_d;
      x1_q       <= x1_d;
      y1_q       <= y1_d;
      vld2_q     <= vld2_d;
      box2_q     <= box2_d;
      x2_q       <= x2_d;
      y2_q       <= y2_d;
      img_q      <= img_d;
      img_vld_q  <= img_vld_d;
      ox_q       <= ox_d;
      oy_q       <= oy_d;
    end
  end

  assign rom_addr  = rom_addr_q;
  assign img       = img_q;
  assign img_valid = img_vld_q;
  assign out_DrawX = ox_q;
  assign out_DrawY = oy_q;

endmodule

// File: doc/dk_sprite_fetch.md
# dk_sprite_fetch

Pipelined sprite pixel source feeding the frame compositor. For each scanned pixel it tests DrawX/DrawY against Donkey Kong's box, computes the sprite ROM address (animation frame and horizontal mirroring included), issues the read to a synchronous sprite ROM and returns an aligned 16-bit RGB565 `img` pixel. Outside the box it returns the transparent key, so the compositor shows background. Sits between the VGA scan counters and the compositor's `img` input.

## Interface
- SPR_W, 80, sprite width in pixels
- SPR_H, 100, sprite height in pixels
- FRAMES, 4, animation frames stored back-to-back in ROM
- FRAME_DIV, 6, video frames per animation step
- ADDR_W, 15, ROM address width (FRAMES*SPR_W*SPR_H must be ≤ 2^ADDR_W)
- KEY, 16'h0E3B, transparent colour (R=1, G=49, B=27)
- Clk  in  1  system clock, rising edge
- Reset_n  in  1  asynchronous, active-low reset
- frame_start  in  1  one-cycle pulse at the start of vertical blank
- pix_valid  in  1  DrawX/DrawY carry a pixel this cycle
- DrawX  in  10  scan column
- DrawY  in  10  scan row
- DK_X  in  10  sprite left edge, screen space
- DK_Y  in  10  sprite top edge, screen space
- moving  in  1  DK walking; enables animation
- facing_left  in  1  mirror sprite horizontally
- rom_addr  out  ADDR_W  registered sprite ROM address
- rom_data  in  16  ROM read data, valid one cycle after rom_addr
- img  out  16  RGB565 pixel for the compositor
- img_valid  out  1  img corresponds to a pixel accepted two cycles earlier
- out_DrawX  out  10  DrawX delayed to align with img
- out_DrawY  out  10  DrawY delayed to align with img

## Operation
- Shadow registers: sx, sy, face load DK_X, DK_Y, facing_left only on frame_start. All address math uses the shadow values, so there is no mid-frame tearing.
- Animation: div counter (0..FRAME_DIV-1) and frame (0..FRAMES-1).
  - On frame_start with moving=1: div increments. On wrap from FRAME_DIV-1 to 0, frame increments, and FRAMES-1 wraps to 0.
  - On frame_start with moving=0: div and frame are cleared to 0.
- Stage 0, on pix_valid:
  - in_box = (DrawX ≥ sx) && (DrawX < sx+SPR_W) && (DrawY ≥ sy) && (DrawY < sy+SPR_H). All comparisons are 11-bit zero-extended, so sx near 1023 does not overflow.
  - lx = DrawX−sx, ly = DrawY−sy. If face=1, lx ← SPR_W−1−lx.
  - rom_addr ← frame*SPR_W*SPR_H + ly*SPR_W + lx when in_box, else 0. The address is registered.
- Stage 1: in_box, valid and DrawX/DrawY are delayed one cycle while the ROM responds.
- Stage 2: img ← in_box_d ? rom_data : KEY. img_valid ← valid_d, and out_DrawX/out_DrawY are registered alongside.
- Pixels are not accepted while pix_valid=0. Pipeline stages advance every cycle; there is no stall input.

## Timing
- Latency is exactly 2 cycles from a pix_valid pixel at edge N to img/img_valid at edge N+2. Throughput is 1 pixel/cycle.
- rom_addr is valid 1 cycle after the accepting edge. rom_data is sampled 1 cycle later.
- frame_start and pix_valid in the same cycle: that pixel already uses the updated shadow values and frame.
- Reset values: rom_addr=0, img=KEY, img_valid=0, out_DrawX=0, out_DrawY=0, shadows=0, div=0, frame=0.
- Reset mid-line: the pipeline is flushed. img_valid stays 0 until 2 cycles after the first pix_valid following Reset_n release.
- Box edges: DrawX=sx and DrawY=sy are inside. DrawX=sx+SPR_W and DrawY=sy+SPR_H are outside.
- Box partially off-screen (sx>560): only on-screen columns are fetched, and no address wraps.

## Test plan
- Reset, then DK_X=100, DK_Y=200, facing_left=0, frame_start. Pixel (100,200) → rom_addr=0 after 1 cycle; img=rom_data and img_valid=1 after 2 cycles. Pixel (179,299) → rom_addr=7999.
- facing_left=1 with the same position. Pixel (100,200) → rom_addr=79; pixel (179,200) → rom_addr=0.
- Boundary: pixels (99,200), (180,200), (100,199), (100,300) → img=KEY. Pixel (179,299) → img=rom_data.
- Animation: moving=1, 6 frame_start pulses → frame=1, pixel (100,200) → rom_addr=8000. After 24 pulses frame wraps to 0. Dropping moving → frame=0 on the next pulse.
- Tearing: change DK_X to 300 mid-frame without frame_start → addresses still use 100. After frame_start, pixel (300,200) → rom_addr=0.
- Stream 640 back-to-back pixels, assert Reset_n=0 at pixel 320 → img_valid drops asynchronously. After release, the first img_valid appears exactly 2 cycles after pix_valid, with matching out_DrawX.
